// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scanner for a 4-digit common-anode
// seven-segment display. One digit nibble is presented per slot, with its
// active-low anode. Each slot starts with dead-time so the previous digit
// does not ghost. Leading zeros can be blanked and any digit can blink.
// All four digits of a frame come from one snapshot of digits_in.
module display_scan_mux #(
   parameter int REFRESH_DIV = 100000,   // cycles per digit slot, >= 2
   parameter int DEAD_CYCLES = 1000,     // blank cycles at slot start
   parameter int BLINK_DIV   = 25000000  // cycles per blink half-period
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits_in,
   input  logic        en,
   input  logic        lzb_en,
   input  logic [3:0]  blink_mask,
   output logic [3:0]  digit_bin,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SLOT_W-1:0]  SLOT_MAX  = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0]  DEAD_END  = SLOT_W'(DEAD_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

   logic [SLOT_W-1:0]  slot_cnt;
   logic [1:0]         idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;
   logic [15:0]        snapshot;
   logic               frame_start;  // first state cycle of a new frame

   logic               slot_wrap;
   logic               frame_wrap;
   logic               blank;
   logic               leading_zero;
   logic [3:0]         nibble;
   logic [3:0]         an_next;

   // Decode wrap points, current nibble and the blanking decision.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      slot_wrap    = 1'b0;
      frame_wrap   = 1'b0;
      blank        = 1'b0;
      leading_zero = 1'b0;
      nibble       = 4'h0;
      an_next      = 4'b1111;

      slot_wrap  = (slot_cnt == SLOT_MAX);
      frame_wrap = slot_wrap && (idx == 2'd3);
      nibble     = snapshot[{idx, 2'b00} +: 4];

      // Digit idx is a leading zero when it and every digit to its left are 0.
      leading_zero = (idx != 2'd0) && ((snapshot >> {idx, 2'b00}) == 16'h0000);

      blank = !en
           || (slot_cnt < DEAD_END)
           || (blink_mask[idx] && blink_phase)
           || (lzb_en && leading_zero);

      an_next = blank ? 4'b1111 : ~(4'b0001 << idx);
   end

   // Slot counter and digit index; idx advances on every slot wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         idx      <= 2'd0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop
         // samples the pre-edge values, independent of statement order.
         if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= idx + 2'd1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

   // Free-running blink timebase, not gated by en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Capture digits_in once per frame, as idx 3 wraps back to idx 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snapshot    <= 16'h0000;
         frame_start <= 1'b0;
      end else begin
         frame_start <= frame_wrap;
         if (frame_wrap) begin
            snapshot <= digits_in;
         end
      end
   end

   // Registered outputs, one cycle behind the scan state. frame_tick lines
   // up with the first cycle digit_bin shows the new snapshot's digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_bin  <= 4'h0;
         an         <= 4'b1111;
         frame_tick <= 1'b0;
      end else begin
         digit_bin  <= nibble;
         an         <= an_next;
         frame_tick <= frame_start;
      end
   end

endmodule
